// File: rtl/risc_pkg.sv
// Shared opcode and controller-state definitions for the risc_nb core.
package risc_pkg;

  // Width of the opcode field at the top of every instruction word.
  localparam int OPCODE_BITS = 3;

  typedef enum logic [2:0] {
    HLT = 3'd0,
    SKZ = 3'd1,
    ADD = 3'd2,
    AND = 3'd3,
    XOR = 3'd4,
    LDA = 3'd5,
    STO = 3'd6,
    JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    WAIT_STEP,
    FETCH,
    DECODE,
    EXEC_RD,
    EXEC_WR,
    HALTED
  } state_t;

endpackage

// File: rtl/risc_alu.sv
// Accumulator datapath: combines the accumulator with memory read data.
module risc_alu
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] res
);

  // Pick the new accumulator value; anything that is not a read-type op keeps in_a.
  always_comb begin
    res = in_a;
    case (opcode_t'(op))
      ADD:     res = in_a + in_b;  // carry out is dropped on purpose
      AND:     res = in_a & in_b;
      XOR:     res = in_a ^ in_b;
      LDA:     res = in_b;
      default: res = in_a;
    endcase
  end

endmodule

// File: rtl/risc_nb.sv
// Multi-cycle accumulator core with a request/ready memory port,
// single-step support and a resumable halt.
// DATA_WIDTH must be at least ADDR_WIDTH+3 so opcode and operand fields do not overlap.
module risc_nb
  import risc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  input  logic                  step_en,
  input  logic                  step_go,
  input  logic                  resume,
  output logic [ADDR_WIDTH-1:0] pc_counter,
  output logic [DATA_WIDTH-1:0] alu_out,
  output logic                  is_zero,
  output logic                  halt
);

  state_t                state_reg;
  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] ir_reg;
  logic [DATA_WIDTH-1:0] acc_reg;
  // Set only by reset: the first cycle after release decides FETCH vs WAIT_STEP
  // from step_en without needing a data-dependent asynchronous reset value.
  logic                  boot_reg;

  opcode_t               opcode;
  logic [ADDR_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] alu_res;
  state_t                done_state;
  logic                  hold_boot;

  assign opcode     = opcode_t'(ir_reg[DATA_WIDTH-1 -: OPCODE_BITS]);
  assign operand    = ir_reg[ADDR_WIDTH-1:0];
  assign done_state = step_en ? WAIT_STEP : FETCH;
  assign hold_boot  = boot_reg && step_en;

  risc_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op  (opcode),
    .in_a(acc_reg),
    .in_b(mem_rdata),
    .res (alu_res)
  );

  // Memory strobes follow the state; gating with rst drops a pending
  // request the moment reset asserts, without waiting for a clock edge.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    if (rst) begin
      case (state_reg)
        FETCH:   mem_req = !hold_boot;
        EXEC_RD: mem_req = 1'b1;
        EXEC_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

  // PC and IR are frozen for the whole access, so the address cannot move while mem_req is high.
  assign mem_addr   = (state_reg == FETCH) ? pc_reg : operand;
  assign mem_wdata  = acc_reg;
  assign pc_counter = pc_reg;
  assign alu_out    = acc_reg;
  assign is_zero    = (acc_reg == '0);
  assign halt       = (state_reg == HALTED);

  // Controller: instruction sequencing plus all PC, IR and accumulator updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= FETCH;
      boot_reg  <= 1'b1;
      pc_reg    <= '0;
      ir_reg    <= '0;
      acc_reg   <= '0;
    end else begin
      boot_reg <= 1'b0;
      case (state_reg)
        WAIT_STEP: begin
          if (step_go) state_reg <= FETCH;
        end
        FETCH: begin
          if (hold_boot) begin
            state_reg <= WAIT_STEP;
          end else if (mem_ready) begin
            ir_reg    <= mem_rdata;
            state_reg <= DECODE;
          end
        end
        DECODE: begin
          pc_reg <= pc_reg + ADDR_WIDTH'(1);
          case (opcode)
            HLT: state_reg <= HALTED;
            SKZ: begin
              if (acc_reg == '0) pc_reg <= pc_reg + ADDR_WIDTH'(2);
              state_reg <= done_state;
            end
            JMP: begin
              pc_reg    <= operand;
              state_reg <= done_state;
            end
            STO:     state_reg <= EXEC_WR;
            default: state_reg <= EXEC_RD;
          endcase
        end
        EXEC_RD: begin
          if (mem_ready) begin
            acc_reg   <= alu_res;
            state_reg <= done_state;
          end
        end
        EXEC_WR: begin
          if (mem_ready) state_reg <= done_state;
        end
        HALTED: begin
          if (resume) state_reg <= done_state;
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/risc_nb.md
RISC_NB -- requirements
Module: risc_nb

Interface
REQ-001 Parameter DATA_WIDTH, default 8: data, accumulator and instruction word width; SHALL satisfy DATA_WIDTH >= ADDR_WIDTH+3.
REQ-002 Parameter ADDR_WIDTH, default 5: program/data address width (2^ADDR_WIDTH words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 mem_req  output  1  memory access request, held until accepted.
REQ-006 mem_we  output  1  1 = write, 0 = read; valid while mem_req=1.
REQ-007 mem_addr  output  ADDR_WIDTH  access address, stable while mem_req=1.
REQ-008 mem_wdata  output  DATA_WIDTH  write data (accumulator value).
REQ-009 mem_rdata  input  DATA_WIDTH  read data, sampled on the edge where mem_req=1 and mem_ready=1.
REQ-010 mem_ready  input  1  access completes on the edge where mem_req=1 and mem_ready=1; ignored otherwise.
REQ-011 step_en  input  1  single-step mode enable.
REQ-012 step_go  input  1  in step mode, a one-cycle pulse releases one instruction.
REQ-013 resume  input  1  leaves HALTED.
REQ-014 pc_counter  output  ADDR_WIDTH  current program counter.
REQ-015 alu_out  output  DATA_WIDTH  registered accumulator value.
REQ-016 is_zero  output  1  alu_out == 0.
REQ-017 halt  output  1  high exactly while in HALTED.

Function
REQ-018 Instruction: opcode = bits [DATA_WIDTH-1 -: 3]; operand address = bits [ADDR_WIDTH-1:0]; remaining bits are ignored.
REQ-019 Opcodes: 0 HLT, 1 SKZ, 2 ADD, 3 AND, 4 XOR, 5 LDA, 6 STO, 7 JMP.
REQ-020 States: WAIT_STEP, FETCH, DECODE, EXEC_RD, EXEC_WR, HALTED.
REQ-021 FETCH: mem_req=1, mem_we=0, mem_addr=PC; on accept, load IR and go to DECODE.
REQ-022 DECODE: PC <= PC+1, modulo 2^ADDR_WIDTH (wraps from all-ones to 0).
REQ-023 DECODE next state by opcode:
- HLT -> HALTED.
- SKZ -> FETCH; if accumulator==0, PC advances by 2 in total.
- JMP -> FETCH with PC <= operand.
- ADD/AND/XOR/LDA -> EXEC_RD.
- STO -> EXEC_WR.
REQ-024 EXEC_RD: reads operand address; on accept, ACC <= ACC+data (carry discarded, mod 2^DATA_WIDTH) / ACC&data / ACC^data / data.
REQ-025 EXEC_WR: mem_we=1, mem_addr=operand, mem_wdata=ACC; completes on accept.
REQ-026 Accumulator and PC SHALL change only as stated in REQ-022 to REQ-025.
REQ-027 Zero-wait memory (mem_ready tied high): HLT/SKZ/JMP take 2 cycles; ADD/AND/XOR/LDA/STO take 3 cycles; each wait cycle adds 1.
REQ-028 Each memory access SHALL complete before the next begins; mem_req SHALL be 0 in DECODE, WAIT_STEP and HALTED.
REQ-029 After instruction completion, with step_en=1 the next state is WAIT_STEP instead of FETCH; WAIT_STEP -> FETCH on step_go=1.
REQ-030 step_go is ignored outside WAIT_STEP; step_en is sampled only at instruction completion.
REQ-031 HALTED -> FETCH (or WAIT_STEP if step_en=1) on resume=1, with PC pointing to the instruction after HLT.
REQ-032 mem_ready=1 while mem_req=0 SHALL have no effect.

Reset
REQ-033 rst=0 asynchronously clears PC, IR and ACC to 0, sets mem_req=0 and mem_we=0, and sets state to FETCH (or WAIT_STEP if step_en=1 at release), including mid-access.
REQ-034 Reset values: pc_counter=0, alu_out=0, is_zero=1, halt=0, mem_addr=0, mem_wdata=0.

Structure
REQ-035 Shared package risc_pkg SHALL hold the opcode enum (HLT..JMP) and the state enum.
REQ-036 One sub-module risc_alu: combinational 3-bit opcode, inA, inB -> res; the controller FSM, PC, IR and ACC live in risc_nb.

Verification
REQ-037 Zero-wait memory holding LDA 20, ADD 21, STO 22, HLT with mem[20]=8'h05, mem[21]=8'h03 -> mem[22]=8'h08, halt=1 after 11 cycles, pc_counter=4.
REQ-038 mem_ready held low 3 cycles during the ADD operand read -> mem_req, mem_addr and mem_we stay stable, ACC unchanged until the accept edge, instruction takes 6 cycles.
REQ-039 ACC=0 then SKZ at PC=2 -> next fetch at address 4; ACC=8'h01 -> next fetch at address 3.
REQ-040 JMP 31 executed at PC=31 (ADDR_WIDTH=5) -> PC=31 repeatedly; a non-jump instruction at 31 -> next fetch at address 0.
REQ-041 step_en=1, step_go pulsed twice -> exactly two instructions execute; the core idles in WAIT_STEP with mem_req=0.
REQ-042 rst asserted during an EXEC_WR wait state -> mem_req drops immediately with no clock edge, no write completes, and after release fetch restarts at address 0.
